// File: rtl/fpga20_bus_sync.sv
// fpga20_bus_sync: brings the asynchronous Z80 strobes and PHI clock into the
// CLK1 domain, detects PHI rising edges and drives two free-running blink
// signals (one paced by PHI edges, one by CLK1).

// Single-bit synchroniser: a shift chain whose last stage is the output.
module fpga20_bus_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic CLK1,
    input  logic RST,
    input  logic sig,
    output logic synced
);
    logic [STAGES-1:0] chain;

    // Shift the sampled input through the chain; reset clears every stage.
    always_ff @(posedge CLK1) begin
        if (RST) chain <= '0;
        else     chain <= {chain[STAGES-2:0], sig};
    end

    assign synced = chain[STAGES-1];
endmodule

module fpga20_bus_sync #(
    parameter int SYNC_STAGES  = 2,
    parameter int PHI_DIV_BITS = 24,
    parameter int CLK_DIV_BITS = 26
) (
    input  logic CLK1,
    input  logic RST,
    input  logic PHI,
    input  logic IORQ,
    input  logic RD,
    input  logic WR,
    output logic io_read,
    output logic io_write,
    output logic phi_read,
    output logic phi_edge,
    output logic blink1,
    output logic blink2
);
    localparam int NUM_SYNC = 3;

    // Lane 0: read term, lane 1: write term, lane 2: raw PHI level.
    // Strobes are combined before the first flop so each term crosses the
    // domain as a single bit.
    logic [NUM_SYNC-1:0] sync_in;
    logic [NUM_SYNC-1:0] sync_out;

    assign sync_in[0] = ~IORQ & ~RD;
    assign sync_in[1] = ~IORQ & ~WR;
    assign sync_in[2] = PHI;

    genvar g;
    generate
        for (g = 0; g < NUM_SYNC; g++) begin : g_sync
            fpga20_bus_sync_cell #(.STAGES(SYNC_STAGES)) u_cell (
                .CLK1   (CLK1),
                .RST    (RST),
                .sig    (sync_in[g]),
                .synced (sync_out[g])
            );
        end
    endgenerate

    assign io_read  = sync_out[0];
    assign io_write = sync_out[1];
    assign phi_read = sync_out[2];

    logic                    phi_prev;
    logic [PHI_DIV_BITS-1:0] phi_cnt;
    logic [CLK_DIV_BITS-1:0] clk_cnt;

    // Registered rising-edge detect on the synchronised PHI level.
    // phi_prev clears on reset, so a PHI already high after reset still
    // produces one pulse once the synchroniser refills.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            phi_prev <= 1'b0;
            phi_edge <= 1'b0;
        end else begin
            phi_prev <= phi_read;
            phi_edge <= phi_read & ~phi_prev;
        end
    end

    // PHI-edge counter; wraps naturally at 2^PHI_DIV_BITS.
    always_ff @(posedge CLK1) begin
        if (RST)           phi_cnt <= '0;
        else if (phi_edge) phi_cnt <= phi_cnt + PHI_DIV_BITS'(1);
    end

    // Free-running CLK1 counter.
    always_ff @(posedge CLK1) begin
        if (RST) clk_cnt <= '0;
        else     clk_cnt <= clk_cnt + CLK_DIV_BITS'(1);
    end

    assign blink1 = phi_cnt[PHI_DIV_BITS-1];
    assign blink2 = clk_cnt[CLK_DIV_BITS-1];
endmodule

// File: tb/tb_fpga20_bus_sync.sv
// Directed bench for fpga20_bus_sync with small divider widths so both
// blink outputs toggle within a short run.
module tb_fpga20_bus_sync;
    logic CLK1 = 1'b0;
    logic RST  = 1'b1;
    logic PHI  = 1'b0;
    logic IORQ = 1'b1;
    logic RD   = 1'b1;
    logic WR   = 1'b1;
    logic io_read, io_write, phi_read, phi_edge, blink1, blink2;

    int tests = 0;
    int fails = 0;

    fpga20_bus_sync #(
        .SYNC_STAGES  (2),
        .PHI_DIV_BITS (3),
        .CLK_DIV_BITS (4)
    ) dut (
        .CLK1     (CLK1),
        .RST      (RST),
        .PHI      (PHI),
        .IORQ     (IORQ),
        .RD       (RD),
        .WR       (WR),
        .io_read  (io_read),
        .io_write (io_write),
        .phi_read (phi_read),
        .phi_edge (phi_edge),
        .blink1   (blink1),
        .blink2   (blink2)
    );

    always #5 CLK1 = ~CLK1;

    // Advance one edge; outputs are settled 1 ns later, inputs change here too.
    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        RST = 1'b1; IORQ = 1'b0; RD = 1'b0; WR = 1'b1;
        for (int r = 0; r < 3; r++) begin
            PHI = r[0];
            tick();
            outs = {io_read, io_write, phi_read, phi_edge, blink1, blink2};
            tests++;
            if (outs !== 6'b0) begin
                fails++;
                $display("FAIL reset_hold[%0d] outs=%b expected=000000", r, outs);
            end
        end
        RST = 1'b0; PHI = 1'b0;
        tick();
        outs = {io_read, io_write, phi_read, phi_edge, blink1, blink2};
        tests++;
        if (outs !== 6'b0) begin
            fails++;
            $display("FAIL reset_release1 outs=%b expected=000000", outs);
        end
        tick();
        tests++;
        if (io_read !== 1'b1) begin
            fails++;
            $display("FAIL reset_release2_io_read got=%b expected=1", io_read);
        end
        IORQ = 1'b1; RD = 1'b1;
    endtask

    // Drive a strobe pattern, check the two synchronised outputs over four edges.
    task automatic strobe_seq(input string name, input logic rd_n, input logic wr_n,
                              input logic exp_rd, input logic exp_wr);
        logic [1:0] got, exp;
        IORQ = 1'b1; RD = 1'b1; WR = 1'b1;
        tick(); tick();
        IORQ = 1'b0; RD = rd_n; WR = wr_n;
        tick();
        got = {io_read, io_write};
        tests++;
        if (got !== 2'b00) begin
            fails++;
            $display("FAIL %s_edge_k got=%b expected=00", name, got);
        end
        tick();
        got = {io_read, io_write}; exp = {exp_rd, exp_wr};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s_edge_k1 got=%b expected=%b", name, got, exp);
        end
        RD = 1'b1; WR = 1'b1;
        tick();
        got = {io_read, io_write};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s_release_edge1 got=%b expected=%b", name, got, exp);
        end
        tick();
        got = {io_read, io_write};
        tests++;
        if (got !== 2'b00) begin
            fails++;
            $display("FAIL %s_release_edge2 got=%b expected=00", name, got);
        end
        IORQ = 1'b1;
    endtask

    task automatic test_read_strobe();
        strobe_seq("read", 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_write_strobe();
        strobe_seq("write", 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_both_strobes();
        strobe_seq("both", 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_glitch();
        logic exp;
        IORQ = 1'b1; RD = 1'b0; WR = 1'b1;
        tick(); tick();
        IORQ = 1'b0;
        tick();
        IORQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i == 1);
            tests++;
            if (io_read !== exp) begin
                fails++;
                $display("FAIL glitch[%0d] io_read=%b expected=%b", i, io_read, exp);
            end
            tick();
        end
        RD = 1'b1;
    endtask

    // PHI high for edges 3..5, 9..11, ...: rises at 3+6n, pulse after edge 5+6n.
    task automatic test_phi_edges();
        logic exp_edge, exp_phi;
        int pulses;
        PHI = 1'b0; IORQ = 1'b1; RD = 1'b1; WR = 1'b1;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            PHI = ((i / 3) % 2) == 1;
            tick();
            exp_edge = (i >= 5) && ((i - 5) % 6 == 0);
            exp_phi  = (i >= 1) && (((i - 1) / 3) % 2 == 1);
            if (phi_edge === 1'b1) pulses++;
            tests++;
            if (phi_edge !== exp_edge || phi_read !== exp_phi) begin
                fails++;
                $display("FAIL phi_edge[%0d] edge=%b read=%b expected edge=%b read=%b",
                         i, phi_edge, phi_read, exp_edge, exp_phi);
            end
        end
        tests++;
        if (pulses != 6) begin
            fails++;
            $display("FAIL phi_pulse_count got=%0d expected=6", pulses);
        end
        PHI = 1'b0;
    endtask

    // 3-bit PHI counter: blink1 follows bit 2 of the number of earlier pulses.
    task automatic test_blink1();
        int cnt;
        logic exp;
        PHI = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 62; i++) begin
            PHI = ((i / 3) % 2) == 1;
            tick();
            exp = ((cnt >> 2) & 1) == 1;
            tests++;
            if (blink1 !== exp) begin
                fails++;
                $display("FAIL blink1[%0d] got=%b expected=%b (pulses=%0d)", i, blink1, exp, cnt);
            end
            if ((i >= 5) && ((i - 5) % 6 == 0)) cnt++;
        end
        PHI = 1'b0;
    endtask

    // 4-bit CLK1 counter, including a restart from a reset at cycle 12.
    task automatic test_blink2();
        logic exp;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            tick();
            exp = (n % 16) >= 8;
            tests++;
            if (blink2 !== exp) begin
                fails++;
                $display("FAIL blink2_cycle%0d got=%b expected=%b", n, blink2, exp);
            end
        end
        do_reset();
        for (int n = 1; n <= 11; n++) tick();
        RST = 1'b1;
        tick();
        tests++;
        if (blink2 !== 1'b0) begin
            fails++;
            $display("FAIL blink2_midreset got=%b expected=0", blink2);
        end
        RST = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp = (n >= 8);
            tests++;
            if (blink2 !== exp) begin
                fails++;
                $display("FAIL blink2_restart%0d got=%b expected=%b", n, blink2, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_strobe();
        test_write_strobe();
        test_both_strobes();
        test_glitch();
        test_phi_edges();
        test_blink1();
        test_blink2();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
